// File: rtl/term_vram_writer.sv
// term_vram_writer: turns a UART byte stream into character VRAM writes, tracking a text cursor.
// Define TERM_ANSI_EN to compile in ESC/CSI parsing, where ESC [ 2 J clears the screen.
module term_vram_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);
  localparam logic [6:0] CMAX = 7'(COLS - 1);
  localparam logic [4:0] RMAX = 5'(ROWS - 1);
`ifdef TERM_ANSI_EN
  typedef enum logic [2:0] {IDLE, CLR_LINE, CLR_SCREEN, ESC, CSI} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;
`endif
  state_t state_q, state_d;
  logic [6:0] col_q, col_d, clr_col_q, clr_col_d;
  logic [4:0] row_q, row_d, clr_row_q, clr_row_d, row_nx;
  logic [12:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic ready_q, ready_d, we_q, we_d, accept, wrap;
`ifdef TERM_ANSI_EN
  logic [1:0] csi_q, csi_d;
`endif
  always_comb begin
    accept = byte_valid && ready_q;
    wrap = row_q == RMAX;
    row_nx = wrap ? 5'd0 : row_q + 5'd1;
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    clr_col_d = 7'd0;
    clr_row_d = 5'd0;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
`ifdef TERM_ANSI_EN
    csi_d = 2'd0;
`endif
    case (state_q)
      IDLE: if (accept) begin
        if (byte_data >= 8'h20 && byte_data <= 8'h7E) begin
          we_d = 1'b1;
          addr_d = {1'b0, row_q, col_q};
          data_d = byte_data;
          col_d = (col_q == CMAX) ? 7'd0 : col_q + 7'd1;
          row_d = (col_q == CMAX) ? row_nx : row_q;
          state_d = (col_q == CMAX && wrap) ? CLR_LINE : IDLE;
        end else if (byte_data == 8'h0D) col_d = 7'd0;
        else if (byte_data == 8'h0A) begin
          row_d = row_nx;
          state_d = wrap ? CLR_LINE : IDLE;
        end else if (byte_data == 8'h08 && col_q != 7'd0) begin
          col_d = col_q - 7'd1;
          we_d = 1'b1;
          addr_d = {1'b0, row_q, col_q - 7'd1};
          data_d = 8'h20;
        end else if (byte_data == 8'h0C) state_d = CLR_SCREEN;
`ifdef TERM_ANSI_EN
        else if (byte_data == 8'h1B) state_d = ESC;
`endif
      end
      CLR_LINE: begin
        we_d = 1'b1;
        addr_d = {1'b0, row_q, clr_col_q};
        data_d = 8'h20;
        clr_col_d = clr_col_q + 7'd1;
        state_d = (clr_col_q == CMAX) ? IDLE : CLR_LINE;
      end
      CLR_SCREEN: begin
        we_d = 1'b1;
        addr_d = {1'b0, clr_row_q, clr_col_q};
        data_d = 8'h20;
        clr_col_d = (clr_col_q == CMAX) ? 7'd0 : clr_col_q + 7'd1;
        clr_row_d = (clr_col_q == CMAX) ? clr_row_q + 5'd1 : clr_row_q;
        if (clr_col_q == CMAX && clr_row_q == RMAX) begin
          state_d = IDLE;
          col_d = 7'd0;
          row_d = 5'd0;
        end
      end
`ifdef TERM_ANSI_EN
      ESC: if (accept) state_d = (byte_data == 8'h5B) ? CSI : IDLE;
      CSI: begin
        csi_d = csi_q;
        if (accept) begin
          if (byte_data >= 8'h40 && byte_data <= 8'h7E)
            state_d = (byte_data == 8'h4A && csi_q == 2'd1) ? CLR_SCREEN : IDLE;
          else
            csi_d = (csi_q == 2'd0 && byte_data == 8'h32) ? 2'd1 : 2'd2;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    ready_d = state_d != CLR_LINE && state_d != CLR_SCREEN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= 7'd0;
      row_q <= 5'd0;
      clr_col_q <= 7'd0;
      clr_row_q <= 5'd0;
      addr_q <= 13'd0;
      data_q <= 8'd0;
      we_q <= 1'b0;
      ready_q <= 1'b0;
`ifdef TERM_ANSI_EN
      csi_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      ready_q <= ready_d;
`ifdef TERM_ANSI_EN
      csi_q <= csi_d;
`endif
    end
  end
  assign byte_ready = ready_q;
  assign vram_addr = addr_q;
  assign vram_data = data_q;
  assign vram_we = we_q;
  assign cur_col = col_q;
  assign cur_row = row_q;
endmodule

// File: tb/tb_term_vram_writer.sv
// tb_term_vram_writer: directed vectors plus multi-cycle clear/reset sequences for term_vram_writer.
module tb_term_vram_writer;
  logic clk = 1'b0, rst = 1'b1, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, vram_we;
  logic [12:0] vram_addr;
  logic [7:0] vram_data;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  int n_chk = 0, n_fail = 0;

  term_vram_writer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .vram_addr(vram_addr), .vram_data(vram_data),
    .vram_we(vram_we), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] c; logic [4:0] r; logic [7:0] b;
    logic we; logic [12:0] a; logic [7:0] d; logic [6:0] ec; logic [4:0] er;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!byte_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) chk("ready_wait", byte_ready, 1);
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic goto(input logic [6:0] c, input logic [4:0] r);
    do_reset();
    repeat (int'(r)) send(8'h0A);
    repeat (int'(c)) send(8'h20);
  endtask

  task automatic clear_screen_check(input string nm);
    int n = 0, bad = 0, cyc = 0;
    logic [6:0] ec = 0;
    logic [4:0] er = 0;
    chk({nm, "_ready_low"}, byte_ready, 0);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (vram_we) begin
        if (vram_addr !== {1'b0, er, ec} || vram_data !== 8'h20) bad++;
        n++;
        er = (ec == 7'd79) ? er + 5'd1 : er;
        ec = (ec == 7'd79) ? 7'd0 : ec + 7'd1;
      end
      if (byte_ready) break;
    end
    chk({nm, "_count"}, n, 2400);
    chk({nm, "_seq_errs"}, bad, 0);
    chk({nm, "_cursor"}, {cur_col, cur_row}, 0);
    @(negedge clk);
    chk({nm, "_we_after"}, vram_we, 0);
  endtask

  initial begin
    v[0]  = '{7'd0,  5'd0, 8'h48, 1'b1, 13'h000, 8'h48, 7'd1,  5'd0};
    v[1]  = '{7'd1,  5'd0, 8'h69, 1'b1, 13'h001, 8'h69, 7'd2,  5'd0};
    v[2]  = '{7'd79, 5'd5, 8'h41, 1'b1, 13'h2CF, 8'h41, 7'd0,  5'd6};
    v[3]  = '{7'd10, 5'd4, 8'h0D, 1'b0, 13'h000, 8'h00, 7'd0,  5'd4};
    v[4]  = '{7'd10, 5'd4, 8'h0A, 1'b0, 13'h000, 8'h00, 7'd10, 5'd5};
    v[5]  = '{7'd0,  5'd3, 8'h08, 1'b0, 13'h000, 8'h00, 7'd0,  5'd3};
    v[6]  = '{7'd4,  5'd3, 8'h08, 1'b1, 13'h183, 8'h20, 7'd3,  5'd3};
    v[7]  = '{7'd5,  5'd2, 8'h1B, 1'b0, 13'h000, 8'h00, 7'd5,  5'd2};
    v[8]  = '{7'd5,  5'd2, 8'h7F, 1'b0, 13'h000, 8'h00, 7'd5,  5'd2};
    v[9]  = '{7'd5,  5'd2, 8'h00, 1'b0, 13'h000, 8'h00, 7'd5,  5'd2};
    v[10] = '{7'd5,  5'd2, 8'h7E, 1'b1, 13'h105, 8'h7E, 7'd6,  5'd2};
    v[11] = '{7'd5,  5'd2, 8'h20, 1'b1, 13'h105, 8'h20, 7'd6,  5'd2};
    v[12] = '{7'd5,  5'd2, 8'h80, 1'b0, 13'h000, 8'h00, 7'd5,  5'd2};
    v[13] = '{7'd5,  5'd2, 8'h1F, 1'b0, 13'h000, 8'h00, 7'd5,  5'd2};

    repeat (2) @(negedge clk);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_data, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_cursor", {cur_col, cur_row}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", byte_ready, 1);

    for (int i = 0; i < 14; i++) begin
      goto(v[i].c, v[i].r);
      send(v[i].b);
      chk($sformatf("vec%0d_we", i), vram_we, v[i].we);
      if (v[i].we) begin
        chk($sformatf("vec%0d_addr", i), vram_addr, v[i].a);
        chk($sformatf("vec%0d_data", i), vram_data, v[i].d);
      end
      chk($sformatf("vec%0d_col", i), cur_col, v[i].ec);
      chk($sformatf("vec%0d_row", i), cur_row, v[i].er);
      @(negedge clk);
      chk($sformatf("vec%0d_we_1cyc", i), vram_we, 0);
    end

    goto(7'd10, 5'd29);
    send(8'h0A);
    chk("lf_wrap_we", vram_we, 0);
    chk("lf_wrap_cursor", {cur_col, cur_row}, {7'd10, 5'd0});
    chk("lf_wrap_ready", byte_ready, 0);
    for (int i = 0; i < 80; i++) begin
      if (i == 10) begin byte_valid = 1'b1; byte_data = 8'h51; end
      if (i == 20) byte_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("lf_clr%0d", i), {vram_we, vram_addr, vram_data}, {1'b1, 13'(i), 8'h20});
      chk($sformatf("lf_ready%0d", i), byte_ready, (i == 79) ? 1 : 0);
    end
    @(negedge clk);
    chk("lf_done_we", vram_we, 0);
    chk("lf_no_buffer_cursor", {cur_col, cur_row}, {7'd10, 5'd0});

    goto(7'd79, 5'd29);
    send(8'h5A);
    chk("br_write", {vram_we, vram_addr, vram_data}, {1'b1, 13'hECF, 8'h5A});
    chk("br_cursor", {cur_col, cur_row}, 0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk($sformatf("br_clr%0d", i), {vram_we, vram_addr}, {1'b1, 13'(i)});
    end

    goto(7'd7, 5'd3);
    send(8'h0C);
    clear_screen_check("ff");

    goto(7'd0, 5'd0);
    send(8'h0C);
    repeat (100) @(negedge clk);
    chk("mid_we_before", vram_we, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", vram_we, 0);
    chk("mid_rst_cursor", {cur_col, cur_row}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", byte_ready, 1);
    chk("mid_rst_no_write", vram_we, 0);

`ifdef TERM_ANSI_EN
    goto(7'd3, 5'd1);
    send(8'h1B);
    chk("esc_we", vram_we, 0);
    send(8'h5B);
    send(8'h33);
    send(8'h31);
    send(8'h6D);
    chk("sgr_we", vram_we, 0);
    chk("sgr_cursor", {cur_col, cur_row}, {7'd3, 5'd1});
    send(8'h58);
    chk("sgr_x", {vram_we, vram_addr, vram_data}, {1'b1, 13'h083, 8'h58});
    chk("sgr_x_cursor", {cur_col, cur_row}, {7'd4, 5'd1});
    send(8'h1B);
    send(8'h5B);
    send(8'h32);
    send(8'h4A);
    clear_screen_check("ed2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/term_vram_writer.md
TERM_VRAM_WRITER -- requirements
Module: term_vram_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning number of text columns (1..128).
REQ-002 SHALL have parameter ROWS, default 30, meaning number of text rows (1..32).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port byte_valid, input, 1, received UART byte present.
REQ-006 SHALL have port byte_data, input, 8, received UART byte.
REQ-007 SHALL have port byte_ready, output, 1, block can accept a byte this cycle.
REQ-008 SHALL have port vram_addr, output, 13, character VRAM write address {1'b0, row[4:0], col[6:0]}.
REQ-009 SHALL have port vram_data, output, 8, character code to write.
REQ-010 SHALL have port vram_we, output, 1, one-cycle write strobe.
REQ-011 SHALL have ports cur_col (output, 7) and cur_row (output, 5), the current cursor position.

Function
REQ-012 SHALL accept a byte only on a cycle where byte_valid && byte_ready; otherwise the byte is ignored and nothing is buffered.
REQ-013 SHALL register all outputs; a VRAM write caused by an accepted byte SHALL appear exactly 1 cycle after acceptance, with vram_we high for that single cycle.
REQ-014 SHALL use states IDLE, CLR_LINE and CLR_SCREEN (plus ESC and CSI when REQ-027 applies); byte_ready SHALL be high only in IDLE, ESC and CSI.
REQ-015 SHALL, for a printable byte 0x20..0x7E, write it at (cur_col, cur_row) and advance cur_col by 1.
REQ-016 SHALL wrap at cur_col = COLS-1: writing there sets cur_col=0 and advances the row.
REQ-017 SHALL handle CR (0x0D) as cur_col=0 with no write, and LF (0x0A) as a row advance, cur_col unchanged, with no write.
REQ-018 SHALL handle BS (0x08) as follows: if cur_col>0, decrement cur_col and write 0x20 at the new position; at cur_col=0, no move and no write.
REQ-019 SHALL handle FF (0x0C) by entering CLR_SCREEN, which writes 0x20 to all ROWS*COLS cells, one per cycle, row-major from (0,0), then sets the cursor to (0,0) and returns to IDLE.
REQ-020 SHALL treat a row advance from cur_row<ROWS-1 as cur_row+1; from ROWS-1 it SHALL set cur_row=0 and enter CLR_LINE.
REQ-021 SHALL, in CLR_LINE, write 0x20 to cols 0..COLS-1 of cur_row, one per cycle (COLS writes), then return to IDLE with the cursor unchanged.
REQ-022 SHALL ignore all other bytes 0x00..0x1F and 0x7F..0xFF: no write, no cursor change.
REQ-023 SHALL drive vram_addr bit 12 and any unused column/row bits as 0, and SHALL never write a column >= COLS or a row >= ROWS.

Reset
REQ-024 SHALL, while rst is high, set state=IDLE, cur_col=0, cur_row=0, vram_we=0, vram_addr=0, vram_data=0, and byte_ready=0; byte_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-025 SHALL, when rst is asserted during CLR_LINE, CLR_SCREEN, ESC or CSI, abort the operation immediately with no further writes; VRAM contents are not cleared by reset.

Configuration
REQ-026 SHALL provide the macro TERM_ANSI_EN to compile ANSI escape parsing in or out.
REQ-027 SHALL, with TERM_ANSI_EN defined, enter ESC on 0x1B. In ESC, '[' goes to CSI and any other byte returns to IDLE, discarded. In CSI, bytes 0x30..0x3F are discarded; a final byte 0x40..0x7E returns to IDLE. The sequence ESC [ 2 J enters CLR_SCREEN; all other sequences produce no write and no cursor change.
REQ-028 SHALL, without TERM_ANSI_EN, treat 0x1B as an ignored control byte, print subsequent printable bytes normally, and omit the ESC and CSI states.

Verification
REQ-029 SHALL cover: reset, then bytes "Hi" -> writes (addr 0x000, 0x48) and (addr 0x001, 0x69); cursor (2,0).
REQ-030 SHALL cover: cursor (79,5), byte 'A' -> write addr {5,79}=0x2CF, data 0x41; cursor (0,6).
REQ-031 SHALL cover: cursor (10,29), LF -> cur_row=0; 80 writes of 0x20 to addr 0x000..0x04F; byte_ready low for 80 cycles.
REQ-032 SHALL cover: cursor (0,3) BS -> no write; cursor (4,3) BS -> write 0x20 at 0x183, cursor (3,3).
REQ-033 SHALL cover: TERM_ANSI_EN, bytes ESC [ 3 1 m 'X' -> single write 0x58 at cursor; ESC [ 2 J -> 2400 writes of 0x20, cursor (0,0).
REQ-034 SHALL cover: rst asserted mid-CLR_SCREEN -> vram_we low on the next cycle, cursor (0,0), byte_ready high the cycle after rst drops.
